// File: rtl/kernel_bank_pingpong.sv
// Double-buffered kernel weight store: weights fill the shadow bank while the
// active bank drives kernel_out; a swap promotes the shadow bank in one cycle.
module kernel_bank_pingpong #(
    parameter int DATA_W      = 8,
    parameter int KERNEL_SIZE = 49,
    localparam int PTR_W      = $clog2(KERNEL_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          clear,
    input  logic                          swap_req,
    output logic                          swap_ack,
    output logic                          swap_err,
    output logic                          shadow_full,
    output logic [PTR_W-1:0]              load_count,
    output logic                          kernel_valid,
    output logic [KERNEL_SIZE*DATA_W-1:0] kernel_out
);

    typedef enum logic {FILL, FULL} state_t;

    state_t                        state, state_next;
    logic [PTR_W-1:0]              ptr, ptr_next;
    logic                          bank_sel;
    logic                          wr_en;
    logic                          swap_do;
    logic                          err_do;
    logic [KERNEL_SIZE*DATA_W-1:0] bank0, bank1;

    // Priority: clear beats swap, swap beats write; writes only land while filling.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        wr_en      = 1'b0;
        swap_do    = 1'b0;
        err_do     = 1'b0;
        if (clear) begin
            state_next = FILL;
            ptr_next   = '0;
        end else if (swap_req && state == FULL) begin
            swap_do    = 1'b1;
            state_next = FILL;
            ptr_next   = '0;
        end else begin
            err_do = swap_req;
            if (wr_valid && state == FILL) begin
                wr_en    = 1'b1;
                ptr_next = ptr + PTR_W'(1);
                if (ptr == PTR_W'(KERNEL_SIZE - 1))
                    state_next = FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FILL;
            ptr          <= '0;
            bank_sel     <= 1'b0;
            kernel_valid <= 1'b0;
            swap_ack     <= 1'b0;
            swap_err     <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            swap_ack <= swap_do;
            swap_err <= err_do;
            if (swap_do) begin
                bank_sel     <= ~bank_sel;
                kernel_valid <= 1'b1;
            end
        end
    end

    // The shadow bank is whichever one bank_sel is not pointing at.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank0 <= '0;
            bank1 <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                if (ptr == PTR_W'(i)) begin
                    if (bank_sel)
                        bank0[i*DATA_W +: DATA_W] <= wr_data;
                    else
                        bank1[i*DATA_W +: DATA_W] <= wr_data;
                end
            end
        end
    end

    assign wr_ready    = (state == FILL);
    assign shadow_full = (state == FULL);
    assign load_count  = ptr;
    assign kernel_out  = bank_sel ? bank1 : bank0;

endmodule

// File: tb/tb_kernel_bank_pingpong.sv
// Randomised bench for kernel_bank_pingpong against a queue-based model of the
// shadow fill and the promoted kernel; a second small instance covers 16-bit/9-tap.
module tb_kernel_bank_pingpong;

    localparam int K  = 49;
    localparam int W  = 8;
    localparam int KB = 9;
    localparam int WB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           wr_valid, clear, swap_req;
    logic [W-1:0]   wr_data;
    logic           wr_ready, swap_ack, swap_err, shadow_full, kernel_valid;
    logic [5:0]     load_count;
    logic [K*W-1:0] kernel_out;

    logic            b_wr_valid, b_clear, b_swap_req;
    logic [WB-1:0]   b_wr_data;
    logic            b_wr_ready, b_swap_ack, b_swap_err, b_shadow_full, b_kernel_valid;
    logic [3:0]      b_load_count;
    logic [KB*WB-1:0] b_kernel_out;

    kernel_bank_pingpong #(.DATA_W(W), .KERNEL_SIZE(K)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .clear(clear), .swap_req(swap_req),
        .swap_ack(swap_ack), .swap_err(swap_err), .shadow_full(shadow_full),
        .load_count(load_count), .kernel_valid(kernel_valid), .kernel_out(kernel_out)
    );

    kernel_bank_pingpong #(.DATA_W(WB), .KERNEL_SIZE(KB)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
        .wr_ready(b_wr_ready), .clear(b_clear), .swap_req(b_swap_req),
        .swap_ack(b_swap_ack), .swap_err(b_swap_err), .shadow_full(b_shadow_full),
        .load_count(b_load_count), .kernel_valid(b_kernel_valid), .kernel_out(b_kernel_out)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference: shadow is the list of weights accepted since the last swap/clear;
    // the active kernel is whatever list was last promoted.
    logic [W-1:0] shadow_q[$];
    logic [W-1:0] active[K];
    logic         model_kv;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [K*W-1:0] pack_active();
        logic [K*W-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) r[i*W +: W] = active[i];
        return r;
    endfunction

    task automatic model_reset();
        shadow_q.delete();
        for (int i = 0; i < K; i++) active[i] = '0;
        model_kv = 1'b0;
    endtask

    task automatic check_all(input logic exp_ack, input logic exp_err);
        check_eq("wr_ready", wr_ready, shadow_q.size() < K);
        check_eq("shadow_full", shadow_full, shadow_q.size() == K);
        check_eq("load_count", load_count, shadow_q.size());
        check_eq("swap_ack", swap_ack, exp_ack);
        check_eq("swap_err", swap_err, exp_err);
        check_eq("kernel_valid", kernel_valid, model_kv);
        check_eq("kernel_out", kernel_out, pack_active());
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic c, input logic s);
        logic exp_ack, exp_err;
        wr_valid = v; wr_data = d; clear = c; swap_req = s;
        @(posedge clk);
        #1;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (c) begin
            shadow_q.delete();
        end else if (s && shadow_q.size() == K) begin
            for (int i = 0; i < K; i++) active[i] = shadow_q[i];
            shadow_q.delete();
            model_kv = 1'b1;
            exp_ack  = 1'b1;
        end else begin
            exp_err = s;
            if (v && shadow_q.size() < K) shadow_q.push_back(d);
        end
        wr_valid = 1'b0; clear = 1'b0; swap_req = 1'b0;
        check_all(exp_ack, exp_err);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        logic v;
        int idx, guard;
        logic [KB*WB-1:0] b_exp;

        rst = 1'b0;
        wr_valid = 1'b0; wr_data = '0; clear = 1'b0; swap_req = 1'b0;
        b_wr_valid = 1'b0; b_wr_data = '0; b_clear = 1'b0; b_swap_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0, 1'b0);
        rst = 1'b1;

        // T2: weights 1..K, then promote
        for (int i = 0; i < K; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check_eq("t2_w0", kernel_out[0 +: W], 8'd1);
        check_eq("t2_w48", kernel_out[48*W +: W], 8'd49);

        // T3: kernel B streams in with gaps while A stays active
        idx = 0; guard = 0;
        while (idx < K && guard < 1000) begin
            v = ($urandom_range(0, 2) != 0);
            step(v, W'(8'hA0 + idx), 1'b0, 1'b0);
            if (v) idx++;
            guard++;
        end
        check_eq("t3_fill_done", idx, K);
        step(1'b0, '0, 1'b0, 1'b1);

        // T4: early swap with a write in the same cycle
        fill_random(20);
        step(1'b1, W'($urandom), 1'b0, 1'b1);
        fill_random(K - 21);
        step(1'b0, '0, 1'b0, 1'b1);

        // T5: clear mid-fill (write alongside clear is dropped), then 0x5A kernel
        fill_random(30);
        step(1'b0, '0, 1'b1, 1'b0);
        fill_random(5);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < K; i++) step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check_eq("t5_w17", kernel_out[17*W +: W], 8'h5A);

        // T6: clear+swap while full, then writes offered while full
        fill_random(K);
        step(1'b0, '0, 1'b1, 1'b1);
        fill_random(K);
        repeat (3) step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // T1: asynchronous reset in the middle of a fill
        fill_random(10);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0, 1'b0);
        rst = 1'b1;

        // Random mix of writes, gaps, swaps and clears
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 10) == 0);

        // Wide/short instance: 9 taps of 16 bits
        check_eq("b_kernel_valid_rst", b_kernel_valid, 1'b0);
        check_eq("b_kernel_out_rst", b_kernel_out, '0);
        b_exp = '0;
        for (int i = 0; i < KB; i++) begin
            b_wr_valid = 1'b1;
            b_wr_data  = WB'((i + 1) * 257);
            b_exp[i*WB +: WB] = WB'((i + 1) * 257);
            @(posedge clk);
            #1;
            b_wr_valid = 1'b0;
            check_eq("b_load_count", b_load_count, i + 1);
        end
        check_eq("b_shadow_full", b_shadow_full, 1'b1);
        check_eq("b_wr_ready", b_wr_ready, 1'b0);
        check_eq("b_kernel_out_pre", b_kernel_out, '0);
        b_swap_req = 1'b1;
        @(posedge clk);
        #1;
        b_swap_req = 1'b0;
        check_eq("b_swap_ack", b_swap_ack, 1'b1);
        check_eq("b_swap_err", b_swap_err, 1'b0);
        check_eq("b_kernel_valid", b_kernel_valid, 1'b1);
        check_eq("b_kernel_out", b_kernel_out, b_exp);
        check_eq("b_load_count_post", b_load_count, 0);
        @(posedge clk);
        #1;
        check_eq("b_swap_ack_pulse", b_swap_ack, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
